// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - gate states and motor direction codes shared with the lock sequencer
package lock_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } gate_state_t;

  localparam logic MOTOR_DIR_OPEN  = 1'b1;
  localparam logic MOTOR_DIR_CLOSE = 1'b0;

endpackage

// File: rtl/travel_counter.sv
// rtl/travel_counter.sv - saturating gate position counter, 0 = closed, TRAVEL_CYCLES = open
module travel_counter #(
  parameter int TRAVEL_CYCLES = 16,
  parameter int PW            = $clog2(TRAVEL_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up,
  input  logic          down,
  input  logic          hold,
  output logic [PW-1:0] count,
  output logic          at_min,
  output logic          at_max
);

  localparam logic [PW-1:0] MAX_COUNT = PW'(TRAVEL_CYCLES);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Saturate at both ends so the position can never wrap.
    if (!hold) begin
      if (up && !at_max) begin
        count_d = count_q + PW'(1);
      end else if (down && !at_min) begin
        count_d = count_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_min = (count_q == '0);
  assign at_max = (count_q == MAX_COUNT);

endmodule

// File: rtl/lock_gate_actuator.sv
// rtl/lock_gate_actuator.sv - lock gate travel FSM with level-equal open permit
module lock_gate_actuator
  import lock_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int PW            = $clog2(TRAVEL_CYCLES + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          OpenClose,
  input  logic          LevelEqual,
  output logic          GateOpen,
  output logic          GateClosed,
  output logic          MotorOn,
  output logic          MotorDir,
  output logic          Blocked,
  output logic [PW-1:0] Position
);

  localparam logic [PW-1:0] LAST_STEP  = PW'(TRAVEL_CYCLES - 1);
  localparam logic [PW-1:0] FIRST_STEP = PW'(1);

  gate_state_t state_q;
  gate_state_t state_d;
  logic        blocked_q;
  logic        blocked_d;
  logic        cnt_up;
  logic        cnt_down;
  logic        cnt_hold;
  logic        at_min;
  logic        at_max;
  logic        open_permit;

  assign open_permit = OpenClose && LevelEqual;

  travel_counter #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES),
    .PW           (PW)
  ) u_travel_counter (
    .clk   (Clock),
    .rst_n (Reset),
    .up    (cnt_up),
    .down  (cnt_down),
    .hold  (cnt_hold),
    .count (Position),
    .at_min(at_min),
    .at_max(at_max)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= CLOSED;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blocked_q <= blocked_d;
    end
  end

  // A direction change holds the counter for the one edge the state flips.
  always_comb begin
    state_d   = state_q;
    blocked_d = 1'b0;
    cnt_up    = 1'b0;
    cnt_down  = 1'b0;
    cnt_hold  = 1'b1;
    case (state_q)
      CLOSED: begin
        if (open_permit) begin
          state_d = OPENING;
        end else begin
          blocked_d = OpenClose;
        end
      end
      OPENING: begin
        if (!open_permit) begin
          state_d = CLOSING;
        end else begin
          cnt_up   = 1'b1;
          cnt_hold = 1'b0;
          if (at_max || (Position == LAST_STEP)) begin
            state_d = OPEN;
          end
        end
      end
      OPEN: begin
        if (!OpenClose) begin
          state_d = CLOSING;
        end
      end
      CLOSING: begin
        if (open_permit) begin
          state_d = OPENING;
        end else begin
          cnt_down = 1'b1;
          cnt_hold = 1'b0;
          if (at_min || (Position == FIRST_STEP)) begin
            state_d = CLOSED;
          end
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  always_comb begin
    GateOpen   = (state_q == OPEN);
    GateClosed = (state_q == CLOSED);
    MotorOn    = (state_q == OPENING) || (state_q == CLOSING);
    MotorDir   = (state_q == OPENING) ? MOTOR_DIR_OPEN : MOTOR_DIR_CLOSE;
    Blocked    = blocked_q;
  end

endmodule
